derotation_nco: RTL

//  Receive-side counterpart of the I/Q rotation block: multiplies incoming I/Q by e^(-j*theta)

---
 rtl/derotation_nco.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/derotation_nco.sv
// derotation_nco: phase-accumulator NCO feeding a sin/cos ROM and a complex multiplier
// that rotates each I/Q sample by e^(-j*theta) through a four-stage, enable-gated pipeline.
module derotation_nco #(
  parameter int NB_DATA   = 8,
  parameter int NBF_DATA  = 6,
  parameter int NB_COEFF  = 8,
  parameter int NBF_COEFF = 6,
  parameter int NB_PHASE  = 10
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_valid,
  input  logic                       i_sync,
  input  logic [3:0]                 i_pasoWave,
  input  logic signed [NB_DATA-1:0]  i_dataI,
  input  logic signed [NB_DATA-1:0]  i_dataQ,
  output logic signed [NB_DATA-1:0]  o_dataI,
  output logic signed [NB_DATA-1:0]  o_dataQ,
  output logic                       o_valid,
  output logic [NB_PHASE-1:0]        o_phase
);

  localparam int DEPTH   = 2 ** NB_PHASE;
  localparam int NB_PROD = NB_DATA + NB_COEFF;
  localparam int NB_SUM  = NB_PROD + 1;
  localparam int NBF_SUM = NBF_DATA + NBF_COEFF;
  localparam int SHIFT   = NBF_SUM - NBF_DATA;

  localparam logic signed [NB_SUM-1:0] ROUND_HALF = NB_SUM'(2 ** (SHIFT - 1));
  localparam logic signed [NB_SUM-1:0] OUT_MAX    = NB_SUM'(2 ** (NB_DATA - 1) - 1);
  localparam logic signed [NB_SUM-1:0] OUT_MIN    = -OUT_MAX - 1;

  // Table entry evaluated at elaboration: rounded, saturated sin/cos of k/DEPTH turns.
  function automatic logic signed [NB_COEFF-1:0] lut_val(input int k, input bit want_sin);
    real ang;
    real scaled;
    int  r;
    int  max_v;
    int  min_v;
    ang    = 2.0 * 3.14159265358979323846 * real'(k) / real'(DEPTH);
    scaled = (want_sin ? $sin(ang) : $cos(ang)) * real'(2 ** NBF_COEFF);
    if (scaled >= 0.0) r = $rtoi(scaled + 0.5);
    else               r = -$rtoi(0.5 - scaled);
    max_v = 2 ** (NB_COEFF - 1) - 1;
    min_v = -(2 ** (NB_COEFF - 1));
    if (r > max_v)      r = max_v;
    else if (r < min_v) r = min_v;
    return NB_COEFF'(r);
  endfunction

  function automatic logic signed [NB_DATA-1:0] round_sat(input logic signed [NB_SUM-1:0] s);
    logic signed [NB_SUM-1:0] r;
    r = (s + ROUND_HALF) >>> SHIFT;
    if (r > OUT_MAX) return OUT_MAX[NB_DATA-1:0];
    if (r < OUT_MIN) return OUT_MIN[NB_DATA-1:0];
    return r[NB_DATA-1:0];
  endfunction

  logic signed [NB_COEFF-1:0] cos_rom [DEPTH];
  logic signed [NB_COEFF-1:0] sin_rom [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
      localparam logic signed [NB_COEFF-1:0] COS_V = lut_val(gi, 1'b0);
      localparam logic signed [NB_COEFF-1:0] SIN_V = lut_val(gi, 1'b1);
      assign cos_rom[gi] = COS_V;
      assign sin_rom[gi] = SIN_V;
    end
  endgenerate

  logic [NB_PHASE-1:0]        acc_q, acc_d, sample_phase;
  logic signed [NB_DATA-1:0]  s1_i_q, s1_q_q, s2_i_q, s2_q_q;
  logic [NB_PHASE-1:0]        s1_p_q, s2_p_q, s3_p_q, out_p_q;
  logic                       s1_v_q, s2_v_q, s3_v_q, out_v_q;
  logic signed [NB_COEFF-1:0] cos_q, sin_q;
  logic signed [NB_PROD-1:0]  prod_ic_q, prod_qs_q, prod_qc_q, prod_is_q;
  logic signed [NB_SUM-1:0]   sum_i, sum_q;
  logic signed [NB_DATA-1:0]  out_i_q, out_q_q, out_i_d, out_q_d;

  always_comb begin
    sample_phase = i_sync ? '0 : acc_q;
    acc_d        = acc_q;
    if (i_enable && i_valid) acc_d = sample_phase + NB_PHASE'(i_pasoWave);
    sum_i   = NB_SUM'(prod_ic_q) + NB_SUM'(prod_qs_q);
    sum_q   = NB_SUM'(prod_qc_q) - NB_SUM'(prod_is_q);
    out_i_d = round_sat(sum_i);
    out_q_d = round_sat(sum_q);
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      acc_q     <= '0;
      s1_i_q    <= '0;
      s1_q_q    <= '0;
      s1_p_q    <= '0;
      s1_v_q    <= 1'b0;
      s2_i_q    <= '0;
      s2_q_q    <= '0;
      s2_p_q    <= '0;
      s2_v_q    <= 1'b0;
      cos_q     <= '0;
      sin_q     <= '0;
      prod_ic_q <= '0;
      prod_qs_q <= '0;
      prod_qc_q <= '0;
      prod_is_q <= '0;
      s3_p_q    <= '0;
      s3_v_q    <= 1'b0;
      out_i_q   <= '0;
      out_q_q   <= '0;
      out_p_q   <= '0;
      out_v_q   <= 1'b0;
    end else if (i_enable) begin
      acc_q     <= acc_d;
      s1_i_q    <= i_dataI;
      s1_q_q    <= i_dataQ;
      s1_p_q    <= sample_phase;
      s1_v_q    <= i_valid;
      s2_i_q    <= s1_i_q;
      s2_q_q    <= s1_q_q;
      s2_p_q    <= s1_p_q;
      s2_v_q    <= s1_v_q;
      cos_q     <= cos_rom[s1_p_q];
      sin_q     <= sin_rom[s1_p_q];
      // Full-width products; the sign-extending casts keep the multiply exact.
      prod_ic_q <= NB_PROD'(s2_i_q) * NB_PROD'(cos_q);
      prod_qs_q <= NB_PROD'(s2_q_q) * NB_PROD'(sin_q);
      prod_qc_q <= NB_PROD'(s2_q_q) * NB_PROD'(cos_q);
      prod_is_q <= NB_PROD'(s2_i_q) * NB_PROD'(sin_q);
      s3_p_q    <= s2_p_q;
      s3_v_q    <= s2_v_q;
      out_i_q   <= out_i_d;
      out_q_q   <= out_q_d;
      out_p_q   <= s3_p_q;
      out_v_q   <= s3_v_q;
    end
  end

  assign o_dataI = out_i_q;
  assign o_dataQ = out_q_q;
  assign o_valid = out_v_q;
  assign o_phase = out_p_q;

endmodule
